// File: rtl/pbus_tmr.sv
// pbus_tmr: peripheral-bus timer slave with prescaler, compare match,
// auto-reload and a level interrupt; one-cycle registered response.
module pbus_tmr #(
    parameter int ADDR_SPAN   = 4,
    parameter int PSC_W       = 8,
    parameter int BUS_WIDTH   = 32,
    parameter int BUS_ACC_CNT = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           s_req,
    input  logic [ADDR_SPAN-1:0]           s_addr,
    input  logic                           s_w_rb,
    input  logic [$clog2(BUS_ACC_CNT)-1:0] s_acc,
    input  logic [BUS_WIDTH-1:0]           s_wdata,
    output logic                           s_resp,
    output logic [BUS_WIDTH-1:0]           s_rdata,
    output logic                           s_fault,
    output logic                           irq
);

    localparam int DW = BUS_WIDTH;
    localparam int AW = $clog2(BUS_ACC_CNT);

    logic [DW-1:0]    cnt;
    logic [DW-1:0]    cmp;
    logic             en;
    logic             ar;
    logic             ie;
    logic [PSC_W-1:0] psc;
    logic             mf;
    logic [PSC_W-1:0] psc_cnt;

    logic [1:0]       lane;
    logic [1:0]       sel;
    logic             legal;
    logic [3:0]       byte_en;
    logic [DW-1:0]    bit_en;
    logic [DW-1:0]    wdat_al;
    logic [DW-1:0]    ctrl_word;
    logic [DW-1:0]    cur_word;
    logic [DW-1:0]    shifted;
    logic [DW-1:0]    rd_val;
    logic [DW-1:0]    merged;
    logic             wr;
    logic             rd;
    logic             wr_cnt;
    logic             wr_cmp;
    logic             wr_ctrl;
    logic             wr_stat;
    logic             psc_wr;
    logic             tick;
    logic             hit;
    logic [DW-1:0]    cnt_inc;
    logic [DW-1:0]    cnt_nxt;
    logic             set_mf;
    logic             clr_mf;

    assign lane = s_addr[1:0];
    assign sel  = s_addr[ADDR_SPAN-1:2];

    // Legality, lane enables and lane-replicated write data per access size
    always_comb begin
        legal   = 1'b0;
        byte_en = 4'b0000;
        wdat_al = s_wdata;
        case (s_acc)
            AW'(0): begin
                legal   = 1'b1;
                byte_en = 4'b0001 << lane;
                wdat_al = {4{s_wdata[7:0]}};
            end
            AW'(1): begin
                legal   = ~lane[0];
                byte_en = 4'b0011 << lane;
                wdat_al = {2{s_wdata[15:0]}};
            end
            AW'(2): begin
                legal   = (lane == 2'd0);
                byte_en = 4'b1111;
                wdat_al = s_wdata;
            end
            default: begin
                legal   = 1'b0;
                byte_en = 4'b0000;
                wdat_al = s_wdata;
            end
        endcase
    end

    // Expand lane enables to a per-bit write mask
    always_comb begin
        bit_en = '0;
        for (int i = 0; i < 4; i++) begin
            bit_en[8*i +: 8] = {8{byte_en[i]}};
        end
    end

    // Packed view of CTRL as it appears on the bus
    always_comb begin
        ctrl_word              = '0;
        ctrl_word[0]           = en;
        ctrl_word[1]           = ar;
        ctrl_word[2]           = ie;
        ctrl_word[8 +: PSC_W]  = psc;
    end

    // Select the addressed register and extract the requested lanes
    always_comb begin
        cur_word = '0;
        case (sel)
            2'd0:    cur_word = cnt;
            2'd1:    cur_word = cmp;
            2'd2:    cur_word = ctrl_word;
            default: cur_word = {{(DW-1){1'b0}}, mf};
        endcase
        shifted = cur_word >> {lane, 3'b000};
        case (s_acc)
            AW'(0):  rd_val = {{(DW-8){1'b0}}, shifted[7:0]};
            AW'(1):  rd_val = {{(DW-16){1'b0}}, shifted[15:0]};
            default: rd_val = shifted;
        endcase
    end

    assign merged  = (cur_word & ~bit_en) | (wdat_al & bit_en);
    assign wr      = s_req & s_w_rb & legal;
    assign rd      = s_req & ~s_w_rb & legal;
    assign wr_cnt  = wr & (sel == 2'd0);
    assign wr_cmp  = wr & (sel == 2'd1);
    assign wr_ctrl = wr & (sel == 2'd2);
    assign wr_stat = wr & (sel == 2'd3);
    assign psc_wr  = wr_ctrl & (|bit_en[8 +: PSC_W]);

    assign tick    = en & (psc_cnt == psc);
    assign hit     = ar & (cnt == cmp);
    assign cnt_inc = cnt + DW'(1);
    assign cnt_nxt = hit ? '0 : cnt_inc;
    assign set_mf  = tick & (hit | (cnt_inc == cmp));
    assign clr_mf  = wr_stat & bit_en[0] & wdat_al[0];

    assign irq = mf & ie;

    // Prescaler: free-runs while enabled, restarts on wrap or PSC write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            psc_cnt <= '0;
        end else if (!en || psc_wr || tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PSC_W'(1);
        end
    end

    // Counter: a bus write beats the tick update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (wr_cnt) begin
            cnt <= merged;
        end else if (tick) begin
            cnt <= cnt_nxt;
        end
    end

    // Compare value and control fields
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmp <= '1;
            en  <= 1'b0;
            ar  <= 1'b0;
            ie  <= 1'b0;
            psc <= '0;
        end else begin
            if (wr_cmp) begin
                cmp <= merged;
            end
            if (wr_ctrl) begin
                en  <= merged[0];
                ar  <= merged[1];
                ie  <= merged[2];
                psc <= merged[8 +: PSC_W];
            end
        end
    end

    // Match flag: a new match outranks a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mf <= 1'b0;
        end else if (set_mf) begin
            mf <= 1'b1;
        end else if (clr_mf) begin
            mf <= 1'b0;
        end
    end

    // Registered response, data and fault one cycle after the request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_resp  <= 1'b0;
            s_fault <= 1'b0;
            s_rdata <= '0;
        end else begin
            s_resp  <= s_req;
            s_fault <= s_req & ~legal;
            s_rdata <= rd ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_pbus_tmr.sv
// tb_pbus_tmr: directed and random checks of pbus_tmr against a
// byte-lane behavioural model of the timer register file.
module tb_pbus_tmr;

    logic        clk;
    logic        rstn;
    logic        s_req;
    logic [3:0]  s_addr;
    logic        s_w_rb;
    logic [1:0]  s_acc;
    logic [31:0] s_wdata;
    logic        s_resp;
    logic [31:0] s_rdata;
    logic        s_fault;
    logic        irq;

    int n_vec;
    int n_err;

    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic        m_en;
    logic        m_ar;
    logic        m_ie;
    logic [7:0]  m_psc;
    logic        m_mf;
    logic [7:0]  m_pcnt;

    pbus_tmr dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_w_rb  (s_w_rb),
        .s_acc   (s_acc),
        .s_wdata (s_wdata),
        .s_resp  (s_resp),
        .s_rdata (s_rdata),
        .s_fault (s_fault),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 32'h0;
        m_cmp  = 32'hFFFF_FFFF;
        m_en   = 1'b0;
        m_ar   = 1'b0;
        m_ie   = 1'b0;
        m_psc  = 8'h0;
        m_mf   = 1'b0;
        m_pcnt = 8'h0;
    endtask

    function automatic bit is_legal(input logic [3:0] a,
                                    input logic [1:0] acc);
        if (acc == 2'd3) return 1'b0;
        if (acc == 2'd1 && a[0]) return 1'b0;
        if (acc == 2'd2 && a[1:0] != 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] reg_word(input logic [1:0] idx);
        logic [31:0] w;
        w = 32'h0;
        case (idx)
            2'd0: w = m_cnt;
            2'd1: w = m_cmp;
            2'd2: begin
                w[0]    = m_en;
                w[1]    = m_ar;
                w[2]    = m_ie;
                w[15:8] = m_psc;
            end
            default: w[0] = m_mf;
        endcase
        return w;
    endfunction

    // One bus cycle of the model: response from the pre-edge state,
    // then the timer event and the bus write applied to the state.
    task automatic model_step(input bit req, input bit w,
                              input logic [3:0] a,
                              input logic [1:0] acc,
                              input logic [31:0] wd,
                              output bit e_resp, output bit e_fault,
                              output logic [31:0] e_rd);
        bit ok, tick, reload, set, clr;
        logic [31:0] word, nw, nc;
        logic [7:0] b[4];
        logic [7:0] np;
        int n, lo;
        ok = is_legal(a, acc);
        n  = 1 << acc;
        lo = a[1:0];
        e_resp  = req;
        e_fault = req && !ok;
        e_rd    = 32'h0;
        word    = reg_word(a[3:2]);
        if (req && ok && !w) begin
            for (int i = 0; i < n; i++)
                e_rd[8*i +: 8] = word[8*(lo+i) +: 8];
        end
        tick = m_en && (m_pcnt == m_psc);
        set  = 1'b0;
        clr  = 1'b0;
        nc   = m_cnt;
        if (tick) begin
            reload = m_ar && (m_cnt == m_cmp);
            nc  = reload ? 32'h0 : m_cnt + 32'd1;
            set = reload || (m_cnt + 32'd1 == m_cmp);
        end
        if (!m_en || tick) np = 8'h0;
        else np = m_pcnt + 8'd1;
        if (req && ok && w) begin
            for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
            for (int i = 0; i < n; i++) b[lo+i] = wd[8*i +: 8];
            nw = {b[3], b[2], b[1], b[0]};
            case (a[3:2])
                2'd0: nc = nw;
                2'd1: m_cmp = nw;
                2'd2: begin
                    m_en  = nw[0];
                    m_ar  = nw[1];
                    m_ie  = nw[2];
                    m_psc = nw[15:8];
                    if (lo <= 1 && lo + n > 1) np = 8'h0;
                end
                default: clr = (lo == 0) && wd[0];
            endcase
        end
        m_cnt  = nc;
        m_pcnt = np;
        if (set) m_mf = 1'b1;
        else if (clr) m_mf = 1'b0;
    endtask

    task automatic step(input bit req, input bit w,
                        input logic [3:0] a,
                        input logic [1:0] acc,
                        input logic [31:0] wd);
        bit er, ef;
        logic [31:0] ed;
        @(negedge clk);
        s_req   = req;
        s_w_rb  = w;
        s_addr  = a;
        s_acc   = acc;
        s_wdata = wd;
        model_step(req, w, a, acc, wd, er, ef, ed);
        @(posedge clk);
        #1;
        check("resp", {31'h0, s_resp}, {31'h0, er});
        check("fault", {31'h0, s_fault}, {31'h0, ef});
        check("rdata", s_rdata, ed);
        check("irq", {31'h0, irq}, {31'h0, m_mf & m_ie});
        s_req = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b0, a, 2'd2, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, 2'd2, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    endtask

    initial begin
        int n;
        logic [31:0] seq [6];
        logic [3:0] ra;
        logic [31:0] rw;
        n_vec   = 0;
        n_err   = 0;
        rstn    = 1'b0;
        s_req   = 1'b0;
        s_addr  = 4'h0;
        s_w_rb  = 1'b0;
        s_acc   = 2'd0;
        s_wdata = 32'h0;
        model_reset();
        #12;
        check("rst_resp", {31'h0, s_resp}, 32'h0);
        check("rst_rdata", s_rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        rd(4'h0); check("rst_cnt", s_rdata, 32'h0);
        rd(4'h4); check("rst_cmp", s_rdata, 32'hFFFF_FFFF);
        rd(4'h8); check("rst_ctrl", s_rdata, 32'h0);
        rd(4'hC); check("rst_stat", s_rdata, 32'h0);
        idle();   check("resp_1cyc", {31'h0, s_resp}, 32'h0);

        step(1'b1, 1'b1, 4'h5, 2'd0, 32'h0000_00AB);
        rd(4'h4); check("byte_wr", s_rdata, 32'hFFFF_ABFF);
        step(1'b1, 1'b0, 4'h1, 2'd1, 32'h0);
        check("mis_half", {31'h0, s_fault}, 32'h1);
        step(1'b1, 1'b1, 4'h2, 2'd2, 32'h1234_5678);
        check("mis_word", {31'h0, s_fault}, 32'h1);
        step(1'b1, 1'b1, 4'h4, 2'd3, 32'h0);
        check("bad_acc", {31'h0, s_fault}, 32'h1);
        check("bad_rdata", s_rdata, 32'h0);
        rd(4'h4); check("cmp_kept", s_rdata, 32'hFFFF_ABFF);
        step(1'b1, 1'b0, 4'h6, 2'd1, 32'h0);
        check("half_rd", s_rdata, 32'h0000_FFFF);

        wr(4'h4, 32'd5);
        wr(4'h8, 32'h0000_0205);
        n = 0;
        do begin
            idle();
            n++;
        end while (!irq && n < 40);
        check("irq_rise_cyc", n, 15);
        rd(4'h0); check("cnt_at_match", s_rdata, 32'd5);
        wr(4'hC, 32'h1);
        check("irq_clr", {31'h0, irq}, 32'h0);

        wr(4'h8, 32'h0);
        wr(4'h0, 32'h0);
        wr(4'h4, 32'd3);
        wr(4'hC, 32'h1);
        wr(4'h8, 32'h3);
        seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
        for (int i = 0; i < 6; i++) begin
            rd(4'h0);
            check("ar_seq", s_rdata, seq[i]);
        end
        rd(4'hC); check("ar_mf", s_rdata, 32'h1);

        wr(4'h8, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h0, 32'h0);
        wr(4'h8, 32'h3);
        idle();
        idle();
        wr(4'hC, 32'h1);
        rd(4'hC); check("w1c_vs_set", s_rdata, 32'h1);

        wr(4'h0, 32'h100);
        rd(4'h0); check("cnt_wr_tick", s_rdata, 32'h100);

        wr(4'h8, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h4, 32'hFFFF_FFFF);
        wr(4'h0, 32'hFFFF_FFFE);
        wr(4'h8, 32'h5);
        idle();
        check("wrap_set", {31'h0, irq}, 32'h1);
        wr(4'hC, 32'h1);
        check("wrap_noset", {31'h0, irq}, 32'h0);
        rd(4'hC); check("wrap_stat", s_rdata, 32'h0);
        rd(4'h0); check("wrap_cnt", s_rdata, 32'h1);

        wr(4'h8, 32'h0);
        wr(4'h0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(0, 15));
            rw = $urandom;
            if (ra[3:2] == 2'd2) rw = rw & 32'h0000_03FF;
            else if (ra[3:2] != 2'd3 && $urandom_range(0, 3) != 0)
                rw = 32'($urandom_range(0, 12));
            step($urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), ra,
                 ($urandom_range(0, 7) == 0) ? 2'd3
                     : 2'($urandom_range(0, 2)),
                 rw);
        end

        wr(4'h8, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h4, 32'h1);
        wr(4'h0, 32'h0);
        wr(4'h8, 32'h5);
        idle();
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        rd(4'h4);
        rstn = 1'b0;
        #1;
        check("mid_rst_resp", {31'h0, s_resp}, 32'h0);
        check("mid_rst_rdata", s_rdata, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle();
        check("no_stale", {31'h0, s_resp}, 32'h0);
        rd(4'h0); check("rst2_cnt", s_rdata, 32'h0);
        rd(4'h4); check("rst2_cmp", s_rdata, 32'hFFFF_FFFF);
        rd(4'h8); check("rst2_ctrl", s_rdata, 32'h0);
        rd(4'hC); check("rst2_stat", s_rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
